bcd_binary_codec: RTL and testbench
===================================

// Module: bcd_binary_codec
// PURPOSE
//  Parametrised bidirectional converter between packed BCD and unsigned binary.
//  A mode bit selects the direction per request:
//   - BCD->binary uses the shift-right / subtract-3 method.
//   - binary->BCD uses the shift-left / add-3 (double dabble) method.
//  Inputs are validated; an illegal BCD digit or an out-of-range binary value
//  is reported as an error, and no conversion runs.
//  Sits between numeric display/keypad front-ends and datapath arithmetic.
// PARAMETERS
//  DIGITS  4                    number of BCD digits (>=1); BCD width = 4*DIGITS
//  BIN_W   $clog2(10**DIGITS)   localparam, binary width (14 for DIGITS=4)
// PORTS
//  clk_i     in   1         single clock; all logic on rising edge
//  reset_ni  in   1         asynchronous, active-low reset
//  start_i   in   1         request; accepted only when ready_o=1
//  mode_i    in   1         0: BCD->binary, 1: binary->BCD; sampled at accept
//  bcd_i     in   4*DIGITS  BCD operand (mode 0); sampled at accept
//  bin_i     in   BIN_W     binary operand (mode 1); sampled at accept
//  ready_o   out  1         1 in IDLE (combinational decode of state)
//  done_o    out  1         one-cycle completion pulse
//  error_o   out  1         result status; valid with done_o; held until next accept
//  bcd_o     out  4*DIGITS  BCD side of last completed request
//  bin_o     out  BIN_W     binary side of last completed request
// BEHAVIOUR
//  Reset (reset_ni=0, asynchronous):
//   - state=IDLE, ready_o=1, done_o=0, error_o=0, bcd_o=0, bin_o=0.
//   - Internal shift register and counter are cleared.
//   - A reset mid-conversion aborts the request; no done_o is produced.
//  FSM states: IDLE, CONV, DONE, ERR.
//   - IDLE: ready_o=1. On start_i=1, latch mode and operand, then validate.
//      Valid operand   -> CONV; counter=BIN_W-1.
//      Invalid operand -> ERR.
//      Mode 0 invalid: any nibble of bcd_i > 9.
//      Mode 1 invalid: bin_i >= 10**DIGITS.
//   - CONV: one iteration per cycle. When counter==0 -> DONE, else decrement.
//   - DONE: done_o=1, error_o=0, and the result registers are written.
//      Mode 0: bin_o=result, bcd_o=latched input.
//      Mode 1: bcd_o=result, bin_o=latched input.
//      -> IDLE.
//   - ERR: done_o=1, error_o=1, bcd_o=0, bin_o=0. -> IDLE.
//  start_i outside IDLE is ignored, and operands are not re-sampled.
//  Iteration on the {bcd,bin} register (4*DIGITS+BIN_W bits):
//   - Mode 0: logical shift right by 1, then each 4-bit digit >=8 gets -3.
//   - Mode 1: each digit >=5 gets +3, then logical shift left by 1.
//   - All digit corrections within one iteration are applied in parallel.
//  Latency, with accept on edge 0:
//   - Valid request: CONV spans edges 1..BIN_W; done_o is high in the cycle
//     after edge BIN_W (BIN_W+1 cycles after accept); ready_o returns 1 a
//     cycle later.
//   - Error: done_o is high the cycle after accept.
//  Throughput: one request per BIN_W+2 cycles. A start_i held high is
//   re-accepted on the first IDLE cycle.
//  Outputs hold their values between requests. done_o and ready_o are never
//   both 1.
// TESTING (DIGITS=4, BIN_W=14)
//  1. mode 0, bcd_i=16'h9999 -> done_o 15 cycles after accept, bin_o=9999,
//     bcd_o=16'h9999, error_o=0; also 16'h0000 -> bin_o=0.
//  2. mode 1, bin_i=1234 -> bcd_o=16'h1234; bin_i=9999 -> bcd_o=16'h9999,
//     error_o=0.
//  3. mode 0, bcd_i=16'h12A4 -> done_o the cycle after accept, error_o=1,
//     bin_o=0, bcd_o=0; mode 1, bin_i=10000 -> same error response.
//  4. start_i pulsed during CONV with other operands -> ignored; result
//     matches the first request; done_o pulses exactly once.
//  5. reset_ni low at cycle 5 of CONV -> outputs 0 and ready_o=1
//     immediately; no done_o; the next request converts correctly.
//  6. start_i held high, alternating mode 0 (16'h0042) and mode 1 (42) ->
//     back-to-back results every 16 cycles, bin_o=42 and bcd_o=16'h0042 both
//     times.

Source files
------------

// File: rtl/bcd_binary_codec_if.sv
// ---------------------------------------------------------------------------
// bcd_binary_codec_if
//   Request/response bundle for the BCD <-> binary codec.
//   Requester side (master) drives start_i, mode_i, bcd_i and bin_i.
//   Codec side (slave) returns ready_o, done_o, error_o, bcd_o and bin_o.
//   DIGITS sets the BCD width (4*DIGITS). BIN_W is the width of the binary
//   side, just wide enough for 10**DIGITS-1.
// ---------------------------------------------------------------------------
interface bcd_binary_codec_if #(
  parameter int DIGITS = 4
);
  localparam int BIN_W = $clog2(10**DIGITS);

  logic                  start_i;
  logic                  mode_i;
  logic [4*DIGITS-1:0]   bcd_i;
  logic [BIN_W-1:0]      bin_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  error_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic [BIN_W-1:0]      bin_o;

  modport slave (
    input  start_i, mode_i, bcd_i, bin_i,
    output ready_o, done_o, error_o, bcd_o, bin_o
  );

  modport master (
    output start_i, mode_i, bcd_i, bin_i,
    input  ready_o, done_o, error_o, bcd_o, bin_o
  );
endinterface

// File: rtl/bcd_binary_codec.sv
// ---------------------------------------------------------------------------
// bcd_binary_codec
//   Iterative bidirectional converter between packed BCD and unsigned binary.
//   mode 0: BCD -> binary by shift-right / subtract-3.
//   mode 1: binary -> BCD by add-3 / shift-left (double dabble).
//   Both directions share one {bcd,bin} working register and take BIN_W
//   iterations. Operands are validated at accept time; bad operands skip the
//   conversion and return error_o=1 with zeroed results.
// Ports
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset
//   bus       slave side of bcd_binary_codec_if:
//               start_i/mode_i/bcd_i/bin_i  request, sampled when ready_o=1
//               ready_o                     high in IDLE
//               done_o                      one-cycle completion pulse
//               error_o                     status of last request
//               bcd_o/bin_o                 both sides of last request
// ---------------------------------------------------------------------------
module bcd_binary_codec #(
  parameter int DIGITS = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  bcd_binary_codec_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int BIN_W = $clog2(10**DIGITS);
  localparam int REG_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0]   BIN_LIMIT = (BIN_W + 1)'(10**DIGITS);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [REG_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  op_bcd_q, op_bcd_d;
  logic [BIN_W-1:0]  op_bin_q, op_bin_d;
  logic              error_q, error_d;
  logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;

  // -------------------------------------------------------------------------
  // Operand validation
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] nib_bad;
  logic              bcd_bad;
  logic              bin_bad;
  logic              operand_bad;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_check
    assign nib_bad[gi] = (bus.bcd_i[4*gi +: 4] > 4'd9);
  end

  assign bcd_bad     = |nib_bad;
  assign bin_bad     = ({1'b0, bus.bin_i} >= BIN_LIMIT);
  assign operand_bad = bus.mode_i ? bin_bad : bcd_bad;

  // -------------------------------------------------------------------------
  // One iteration in each direction; digit corrections are parallel.
  // -------------------------------------------------------------------------
  logic [REG_W-1:0] shr;
  logic [REG_W-1:0] iter_r;
  logic [REG_W-1:0] add_pre;
  logic [REG_W-1:0] iter_l;
  logic [BCD_W-1:0] bcd_sub;
  logic [BCD_W-1:0] bcd_add;

  assign shr = shreg_q >> 1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_fix
    // Right-shift path: a digit that picked up the half-weight bit (>=8)
    // overstates by 3 after the shift.
    assign bcd_sub[4*gi +: 4] = (shr[BIN_W + 4*gi +: 4] >= 4'd8)
                              ? shr[BIN_W + 4*gi +: 4] - 4'd3
                              : shr[BIN_W + 4*gi +: 4];
    // Left-shift path: a digit >=5 would double past 9, so pre-add 3.
    assign bcd_add[4*gi +: 4] = (shreg_q[BIN_W + 4*gi +: 4] >= 4'd5)
                              ? shreg_q[BIN_W + 4*gi +: 4] + 4'd3
                              : shreg_q[BIN_W + 4*gi +: 4];
  end

  assign iter_r  = {bcd_sub, shr[BIN_W-1:0]};
  assign add_pre = {bcd_add, shreg_q[BIN_W-1:0]};
  assign iter_l  = add_pre << 1;

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    op_bcd_d  = op_bcd_q;
    op_bin_d  = op_bin_q;
    error_d   = error_q;
    bcd_out_d = bcd_out_q;
    bin_out_d = bin_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          mode_d   = bus.mode_i;
          op_bcd_d = bus.bcd_i;
          op_bin_d = bus.bin_i;
          if (operand_bad) begin
            // Results are cleared now so they are valid alongside done_o.
            state_d   = S_ERR;
            error_d   = 1'b1;
            bcd_out_d = '0;
            bin_out_d = '0;
          end else begin
            state_d = S_CONV;
            error_d = 1'b0;
            cnt_d   = CNT_INIT;
            shreg_d = bus.mode_i ? {{BCD_W{1'b0}}, bus.bin_i}
                                 : {bus.bcd_i, {BIN_W{1'b0}}};
          end
        end
      end

      S_CONV: begin
        shreg_d = mode_q ? iter_l : iter_r;
        if (cnt_q == '0) begin
          // Last iteration: publish from the freshly computed value so the
          // result registers are already correct during the done cycle.
          state_d = S_DONE;
          if (mode_q) begin
            bcd_out_d = iter_l[REG_W-1 -: BCD_W];
            bin_out_d = op_bin_q;
          end else begin
            bcd_out_d = op_bcd_q;
            bin_out_d = iter_r[BIN_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      op_bcd_q  <= '0;
      op_bin_q  <= '0;
      error_q   <= 1'b0;
      bcd_out_q <= '0;
      bin_out_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      op_bcd_q  <= op_bcd_d;
      op_bin_q  <= op_bin_d;
      error_q   <= error_d;
      bcd_out_q <= bcd_out_d;
      bin_out_q <= bin_out_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.done_o  = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.error_o = error_q;
  assign bus.bcd_o   = bcd_out_q;
  assign bus.bin_o   = bin_out_q;

endmodule

// File: tb/tb_bcd_binary_codec.sv
// ---------------------------------------------------------------------------
// tb_bcd_binary_codec
//   Directed bench for bcd_binary_codec with DIGITS=4 (BIN_W=14).
//   Latency is counted in cycles from the cycle in which start_i is presented
//   (accept cycle = 0).
// ---------------------------------------------------------------------------
module tb_bcd_binary_codec;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_binary_codec_if #(.DIGITS(4)) bus ();

  bcd_binary_codec #(.DIGITS(4)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request for a single cycle, then wait (bounded) for done_o.
  task automatic request(input logic m, input logic [15:0] b, input logic [13:0] n,
                         output int lat);
    bus.start_i = 1'b1;
    bus.mode_i  = m;
    bus.bcd_i   = b;
    bus.bin_i   = n;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Check the done cycle, then the return to IDLE one cycle later.
  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic exp_err, input logic [15:0] exp_bcd,
                              input logic [13:0] exp_bin);
    $display("txn %s: lat=%0d err=%0b bcd_o=0x%04h bin_o=%0d", tag, lat,
             bus.error_o, bus.bcd_o, bus.bin_o);
    chk({tag, ".lat"},   lat,          exp_lat);
    chk({tag, ".done"},  bus.done_o,   1'b1);
    chk({tag, ".ready"}, bus.ready_o,  1'b0);
    chk({tag, ".err"},   bus.error_o,  exp_err);
    chk({tag, ".bcd"},   bus.bcd_o,    exp_bcd);
    chk({tag, ".bin"},   bus.bin_o,    exp_bin);
    step(1);
    chk({tag, ".idle_ready"}, bus.ready_o, 1'b1);
    chk({tag, ".idle_done"},  bus.done_o,  1'b0);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_lat;
    logic [15:0] got_bcd;
    logic [13:0] got_bin;

    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.bcd_i   = '0;
    bus.bin_i   = '0;

    // Reset state
    step(2);
    chk("rst.ready", bus.ready_o, 1'b1);
    chk("rst.done",  bus.done_o,  1'b0);
    chk("rst.err",   bus.error_o, 1'b0);
    chk("rst.bcd",   bus.bcd_o,   16'h0000);
    chk("rst.bin",   bus.bin_o,   14'd0);
    rst_n = 1'b1;
    step(1);
    $display("txn reset released");

    // BCD -> binary, largest legal operand and zero
    request(1'b0, 16'h9999, 14'd0, lat);
    check_result("b2n_9999", lat, 15, 1'b0, 16'h9999, 14'd9999);
    request(1'b0, 16'h0000, 14'd0, lat);
    check_result("b2n_0000", lat, 15, 1'b0, 16'h0000, 14'd0);
    request(1'b0, 16'h0807, 14'd0, lat);
    check_result("b2n_0807", lat, 15, 1'b0, 16'h0807, 14'd807);

    // binary -> BCD
    request(1'b1, 16'h0000, 14'd1234, lat);
    check_result("n2b_1234", lat, 15, 1'b0, 16'h1234, 14'd1234);
    request(1'b1, 16'h0000, 14'd9999, lat);
    check_result("n2b_9999", lat, 15, 1'b0, 16'h9999, 14'd9999);
    request(1'b1, 16'h0000, 14'd5, lat);
    check_result("n2b_0005", lat, 15, 1'b0, 16'h0005, 14'd5);

    // Illegal operands: immediate error response with zeroed results
    request(1'b0, 16'h12A4, 14'd0, lat);
    check_result("err_bcd", lat, 1, 1'b1, 16'h0000, 14'd0);
    request(1'b1, 16'h0000, 14'd10000, lat);
    check_result("err_bin", lat, 1, 1'b1, 16'h0000, 14'd0);
    step(3);
    chk("err_hold", bus.error_o, 1'b1);

    // start_i pulsed mid-conversion with different operands is ignored
    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.bcd_i   = 16'h0567;
    bus.bin_i   = 14'd0;
    @(posedge clk);
    #1;
    ndone     = 0;
    first_lat = 0;
    got_bcd   = '0;
    got_bin   = '0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.done_o === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = c;
          got_bcd   = bus.bcd_o;
          got_bin   = bus.bin_o;
        end
      end
      bus.start_i = (c == 4);
      if (c == 4) begin
        bus.mode_i = 1'b1;
        bus.bin_i  = 14'd100;
        bus.bcd_i  = 16'h0100;
      end
      @(posedge clk);
      #1;
    end
    $display("txn ignore_start: dones=%0d lat=%0d bcd_o=0x%04h bin_o=%0d",
             ndone, first_lat, got_bcd, got_bin);
    chk("ign.dones", ndone,     1);
    chk("ign.lat",   first_lat, 15);
    chk("ign.bcd",   got_bcd,   16'h0567);
    chk("ign.bin",   got_bin,   14'd567);
    chk("ign.err",   bus.error_o, 1'b0);

    // Asynchronous reset mid-conversion
    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.bcd_i   = 16'h4321;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    step(5);
    chk("mid.busy", bus.ready_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async_reset mid-conversion");
    chk("ares.ready", bus.ready_o, 1'b1);
    chk("ares.done",  bus.done_o,  1'b0);
    chk("ares.err",   bus.error_o, 1'b0);
    chk("ares.bcd",   bus.bcd_o,   16'h0000);
    chk("ares.bin",   bus.bin_o,   14'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done_o === 1'b1) ndone++;
      step(1);
    end
    chk("ares.no_done", ndone, 0);
    request(1'b0, 16'h4321, 14'd0, lat);
    check_result("ares_next", lat, 15, 1'b0, 16'h4321, 14'd4321);

    // start_i held high, alternating modes: back-to-back every 16 cycles
    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.bcd_i   = 16'h0042;
    bus.bin_i   = 14'd42;
    @(posedge clk);
    #1;
    bus.mode_i = 1'b1;
    bus.bcd_i  = 16'h0099;
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn held_a: lat=%0d bcd_o=0x%04h bin_o=%0d", lat, bus.bcd_o, bus.bin_o);
    chk("held_a.lat", lat,         15);
    chk("held_a.err", bus.error_o, 1'b0);
    chk("held_a.bcd", bus.bcd_o,   16'h0042);
    chk("held_a.bin", bus.bin_o,   14'd42);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.done_o !== 1'b1 && lat < 40);
    bus.start_i = 1'b0;
    $display("txn held_b: period=%0d bcd_o=0x%04h bin_o=%0d", lat, bus.bcd_o, bus.bin_o);
    chk("held_b.period", lat,         16);
    chk("held_b.err",    bus.error_o, 1'b0);
    chk("held_b.bcd",    bus.bcd_o,   16'h0042);
    chk("held_b.bin",    bus.bin_o,   14'd42);
    step(1);
    chk("held.idle", bus.ready_o, 1'b1);
    step(2);
    chk("held.stop", bus.ready_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
